poly_tone_gen: RTL

Parametrised polyphonic square-wave tone generator for the FPGA piano: N debounced key inputs, one independent tone divider per key, a run-time octave shift, and a pulse-density mixer that folds all active voices onto a single speaker pin. It sits between the board switches/GPIO keys and the speaker GPIO bank. It replaces the fixed per-note divider modules plus the separate conditioners and key-to-enable map with one generic block.

---
 rtl/poly_tone_gen_if.sv | 24 ++
 rtl/poly_tone_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/poly_tone_gen_if.sv
// Key/speaker bundle for poly_tone_gen: raw key levels and octave in, debounced levels,
// edge pulses, per-voice tones and the mixed speaker bit out.
// There is no valid/ready handshake: inputs are free-running levels and outputs update every clock.
interface poly_tone_gen_if #(
   parameter int N_KEYS = 8
);
   logic [N_KEYS-1:0] key_i;
   logic [1:0]        oct_i;
   logic [N_KEYS-1:0] key_db_o;
   logic [N_KEYS-1:0] key_on_o;
   logic [N_KEYS-1:0] key_off_o;
   logic [N_KEYS-1:0] tone_o;
   logic              mix_o;

   modport master (
      output key_i, oct_i,
      input  key_db_o, key_on_o, key_off_o, tone_o, mix_o
   );

   modport slave (
      input  key_i, oct_i,
      output key_db_o, key_on_o, key_off_o, tone_o, mix_o
   );
endinterface

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator: per-key sync + debounce, per-key half-period divider
// with octave shift, and a pulse-density mixer onto one speaker bit.
module poly_tone_gen #(
   parameter int N_KEYS     = 8,
   parameter int CNT_W      = 16,
   parameter int DEB_CYCLES = 4,
   parameter int DEB_W      = 3,
   parameter logic [N_KEYS*CNT_W-1:0] HALF_PERIOD = {
      16'd47783, 16'd42560, 16'd37925, 16'd35796,
      16'd31888, 16'd28409, 16'd25309, 16'd23887}
) (
   input  logic           clk,
   input  logic           rst_n,
   poly_tone_gen_if.slave bus
);

   localparam int SW = $clog2(N_KEYS + 1);

   logic [N_KEYS-1:0] s0, s1, db, key_on, key_off, tone;
   logic [DEB_W-1:0]  dcnt   [N_KEYS];
   logic [CNT_W-1:0]  cnt    [N_KEYS];
   logic [CNT_W-1:0]  hp_lat [N_KEYS];
   logic [CNT_W-1:0]  hp_eff [N_KEYS];
   logic [SW-1:0]     pcnt;
   logic [SW-1:0]     sum;
   logic              mix;

   // Shifted half-period, clamped so a very high octave still toggles every clock.
   always_comb begin
      for (int k = 0; k < N_KEYS; k++) begin
         hp_eff[k] = HALF_PERIOD[k*CNT_W +: CNT_W] >> bus.oct_i;
         if (hp_eff[k] == '0) hp_eff[k] = CNT_W'(1);
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < N_KEYS; k++) sum = sum + SW'(tone[k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= '0;
         s1 <= '0;
      end else begin
         s0 <= bus.key_i;
         s1 <= s0;
      end
   end

   // Debounce: a level is accepted only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db      <= '0;
         key_on  <= '0;
         key_off <= '0;
         for (int k = 0; k < N_KEYS; k++) dcnt[k] <= '0;
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            key_on[k]  <= 1'b0;
            key_off[k] <= 1'b0;
            if (s1[k] == db[k]) begin
               dcnt[k] <= '0;
            end else if (dcnt[k] == DEB_W'(DEB_CYCLES - 1)) begin
               db[k]      <= s1[k];
               dcnt[k]    <= '0;
               key_on[k]  <= s1[k];
               key_off[k] <= ~s1[k];
            end else begin
               dcnt[k] <= dcnt[k] + DEB_W'(1);
            end
         end
      end
   end

   // hp_lat only reloads at a half-period boundary so octave changes never cut a half short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone <= '0;
         for (int k = 0; k < N_KEYS; k++) begin
            cnt[k]    <= '0;
            hp_lat[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            if (!db[k]) begin
               cnt[k]    <= '0;
               tone[k]   <= 1'b0;
               hp_lat[k] <= hp_eff[k];
            end else if (cnt[k] == hp_lat[k] - CNT_W'(1)) begin
               cnt[k]    <= '0;
               tone[k]   <= ~tone[k];
               hp_lat[k] <= hp_eff[k];
            end else begin
               cnt[k] <= cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
         mix  <= 1'b0;
      end else begin
         pcnt <= (pcnt == SW'(N_KEYS - 1)) ? '0 : pcnt + SW'(1);
         mix  <= (pcnt < sum);
      end
   end

   assign bus.key_db_o  = db;
   assign bus.key_on_o  = key_on;
   assign bus.key_off_o = key_off;
   assign bus.tone_o    = tone;
   assign bus.mix_o     = mix;

endmodule
